altera_tse_pma_reset_ctrl: RTL and testbench

Reset/powerdown sequencer for the GIGE-mode transceiver channel. It lives on the Avalon register clock and drives the PMA powerdown and reset pins. It releases the TX path after PLL lock and the RX path after CDR lock to data, so the PCS digital-reset synchronizers downstream only see clean, ordered releases. It re-enters the correct phase on loss of lock, on a powerdown request, or while the offset-cancellation reconfig is busy.

---
 rtl/altera_tse_pma_reset_ctrl_if.sv | 43 ++++
 rtl/altera_tse_pma_reset_ctrl.sv | 168 ++++++++++++++++
 tb/tb_altera_tse_pma_reset_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/altera_tse_pma_reset_ctrl_if.sv
// Status and control bundle between the transceiver reset sequencer
// and its surroundings (PCS control bits, GXB status, reconfig block).
interface altera_tse_pma_reset_ctrl_if;
    logic powerdown_req;
    logic pll_locked;
    logic rx_freqlocked;
    logic rx_oc_busy;
    logic gxb_powerdown;
    logic pll_powerdown;
    logic tx_digitalreset;
    logic rx_analogreset;
    logic rx_digitalreset;
    logic tx_ready;
    logic rx_ready;

    modport master (
        output powerdown_req,
        output pll_locked,
        output rx_freqlocked,
        output rx_oc_busy,
        input  gxb_powerdown,
        input  pll_powerdown,
        input  tx_digitalreset,
        input  rx_analogreset,
        input  rx_digitalreset,
        input  tx_ready,
        input  rx_ready
    );

    modport slave (
        input  powerdown_req,
        input  pll_locked,
        input  rx_freqlocked,
        input  rx_oc_busy,
        output gxb_powerdown,
        output pll_powerdown,
        output tx_digitalreset,
        output rx_analogreset,
        output rx_digitalreset,
        output tx_ready,
        output rx_ready
    );
endinterface

// File: rtl/altera_tse_pma_reset_ctrl.sv
// GIGE transceiver reset/powerdown sequencer: powerdown -> PLL lock ->
// TX release -> CDR lock -> RX release, re-entering on any loss event.
module altera_tse_pma_reset_ctrl #(
    parameter int PD_CYCLES          = 8,
    parameter int PLL_STABLE_CYCLES  = 16,
    parameter int RX_STABLE_CYCLES   = 16,
    parameter int SYNCHRONIZER_DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    altera_tse_pma_reset_ctrl_if.slave    bus
);

    localparam int MAX_AB  = (PD_CYCLES > PLL_STABLE_CYCLES) ?
                             PD_CYCLES : PLL_STABLE_CYCLES;
    localparam int CNT_MAX = (MAX_AB > RX_STABLE_CYCLES) ?
                             MAX_AB : RX_STABLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] PD_LOAD  = CW'(PD_CYCLES - 1);
    localparam logic [CW-1:0] PLL_LOAD = CW'(PLL_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] RX_LOAD  = CW'(RX_STABLE_CYCLES - 1);

    // {gxb_pd, pll_pd, tx_dr, rx_ar, rx_dr, tx_rdy, rx_rdy}
    localparam logic [6:0] O_PWRDN    = 7'b1111100;
    localparam logic [6:0] O_PLL_WAIT = 7'b0011100;
    localparam logic [6:0] O_TX_REL   = 7'b0001110;
    localparam logic [6:0] O_RX_LOCK  = 7'b0000110;
    localparam logic [6:0] O_READY    = 7'b0000011;

    typedef enum logic [2:0] {
        S_PWRDN    = 3'd0,
        S_PLL_WAIT = 3'd1,
        S_TX_REL   = 3'd2,
        S_RX_LOCK  = 3'd3,
        S_READY    = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_nxt;
    logic [CW-1:0]               r_cnt;
    logic [CW-1:0]               w_cnt;
    logic [6:0]                  r_out;
    logic [6:0]                  w_out;
    logic [SYNCHRONIZER_DEPTH-1:0] r_pll_sync;
    logic [SYNCHRONIZER_DEPTH-1:0] r_rx_sync;
    logic                        w_pll_s;
    logic                        w_rx_s;
    logic                        w_tx_up;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pll_sync <= '0;
            r_rx_sync  <= '0;
        end else begin
            r_pll_sync <= {r_pll_sync[SYNCHRONIZER_DEPTH-2:0],
                           bus.pll_locked};
            r_rx_sync  <= {r_rx_sync[SYNCHRONIZER_DEPTH-2:0],
                           bus.rx_freqlocked};
        end
    end

    assign w_pll_s = r_pll_sync[SYNCHRONIZER_DEPTH-1];
    assign w_rx_s  = r_rx_sync[SYNCHRONIZER_DEPTH-1];
    assign w_tx_up = (r_state == S_TX_REL) ||
                     (r_state == S_RX_LOCK) ||
                     (r_state == S_READY);

    // Reset is treated as a PWRDN entry so the powerdown minimum applies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_PWRDN;
            r_cnt   <= PD_LOAD;
            r_out   <= O_PWRDN;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt;
            r_out   <= w_out;
        end
    end

    always_comb begin
        w_nxt = r_state;
        w_cnt = r_cnt;
        if (bus.powerdown_req) begin
            w_nxt = S_PWRDN;
            if (r_state != S_PWRDN)
                w_cnt = PD_LOAD;
        end else if (!w_pll_s && w_tx_up) begin
            w_nxt = S_PLL_WAIT;
            w_cnt = PLL_LOAD;
        end else if (!w_rx_s && r_state == S_READY) begin
            w_nxt = S_RX_LOCK;
            w_cnt = RX_LOAD;
        end else if (bus.rx_oc_busy && r_state == S_READY) begin
            w_nxt = S_TX_REL;
            w_cnt = '0;
        end else begin
            unique case (r_state)
                S_PWRDN: begin
                    if (r_cnt == '0) begin
                        w_nxt = S_PLL_WAIT;
                        w_cnt = PLL_LOAD;
                    end else begin
                        w_cnt = r_cnt - 1'b1;
                    end
                end
                S_PLL_WAIT: begin
                    if (!w_pll_s) begin
                        w_cnt = PLL_LOAD;
                    end else if (r_cnt == '0) begin
                        w_nxt = S_TX_REL;
                        w_cnt = '0;
                    end else begin
                        w_cnt = r_cnt - 1'b1;
                    end
                end
                S_TX_REL: begin
                    if (!bus.rx_oc_busy) begin
                        w_nxt = S_RX_LOCK;
                        w_cnt = RX_LOAD;
                    end
                end
                S_RX_LOCK: begin
                    if (bus.rx_oc_busy) begin
                        w_nxt = S_TX_REL;
                        w_cnt = '0;
                    end else if (!w_rx_s) begin
                        w_cnt = RX_LOAD;
                    end else if (r_cnt == '0) begin
                        w_nxt = S_READY;
                    end else begin
                        w_cnt = r_cnt - 1'b1;
                    end
                end
                S_READY: begin
                    w_nxt = S_READY;
                end
                default: begin
                    w_nxt = S_PWRDN;
                    w_cnt = PD_LOAD;
                end
            endcase
        end
    end

    // Decoded from next state so outputs line up with the state register.
    always_comb begin
        w_out = O_PWRDN;
        unique case (w_nxt)
            S_PWRDN:    w_out = O_PWRDN;
            S_PLL_WAIT: w_out = O_PLL_WAIT;
            S_TX_REL:   w_out = O_TX_REL;
            S_RX_LOCK:  w_out = O_RX_LOCK;
            S_READY:    w_out = O_READY;
            default:    w_out = O_PWRDN;
        endcase
    end

    assign bus.gxb_powerdown   = r_out[6];
    assign bus.pll_powerdown   = r_out[5];
    assign bus.tx_digitalreset = r_out[4];
    assign bus.rx_analogreset  = r_out[3];
    assign bus.rx_digitalreset = r_out[2];
    assign bus.tx_ready        = r_out[1];
    assign bus.rx_ready        = r_out[0];

endmodule

// File: tb/tb_altera_tse_pma_reset_ctrl.sv
// Directed bench: expected output vectors are scheduled per cycle in a
// queue and compared when the DUT reaches that cycle.
module tb_altera_tse_pma_reset_ctrl;

    // {gxb_pd, pll_pd, tx_dr, rx_ar, rx_dr, tx_rdy, rx_rdy}
    localparam logic [6:0] V_PWRDN    = 7'b1111100;
    localparam logic [6:0] V_PLL_WAIT = 7'b0011100;
    localparam logic [6:0] V_TX_REL   = 7'b0001110;
    localparam logic [6:0] V_RX_LOCK  = 7'b0000110;
    localparam logic [6:0] V_READY    = 7'b0000011;

    typedef struct {
        int         cyc;
        string      tag;
        logic [6:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   t0 = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    exp_t sb[$];

    altera_tse_pma_reset_ctrl_if bus ();

    altera_tse_pma_reset_ctrl #(
        .PD_CYCLES(8),
        .PLL_STABLE_CYCLES(16),
        .RX_STABLE_CYCLES(16),
        .SYNCHRONIZER_DEPTH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] outs();
        return {bus.gxb_powerdown, bus.pll_powerdown, bus.tx_digitalreset,
                bus.rx_analogreset, bus.rx_digitalreset, bus.tx_ready,
                bus.rx_ready};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs,
                       input logic [6:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_at(input int k, input string tag,
                             input logic [6:0] v);
        exp_t e;
        e.cyc = t0 + k;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_due();
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].cyc == cyc) begin
                chk(sb[j].tag, outs(), sb[j].exp);
                sb.delete(j);
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_due();
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.powerdown_req = 1'b0;
        bus.pll_locked    = 1'b1;
        bus.rx_freqlocked = 1'b1;
        bus.rx_oc_busy    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", outs(), V_PWRDN);

        // power-up with locks already present
        reset = 1'b0;
        t0 = cyc;
        expect_at(7,  "up_pd_hold",   V_PWRDN);
        expect_at(8,  "up_pll_wait",  V_PLL_WAIT);
        expect_at(23, "up_pll_last",  V_PLL_WAIT);
        expect_at(24, "up_tx_rel",    V_TX_REL);
        expect_at(25, "up_rx_lock",   V_RX_LOCK);
        expect_at(40, "up_rx_last",   V_RX_LOCK);
        expect_at(41, "up_ready",     V_READY);
        step(45);

        // PLL lock lost for 5 cycles
        bus.pll_locked = 1'b0;
        t0 = cyc;
        expect_at(3,  "pll_sync_dly", V_READY);
        expect_at(4,  "pll_lost",     V_PLL_WAIT);
        expect_at(8,  "pll_reload",   V_PLL_WAIT);
        expect_at(23, "pll_rl_last",  V_PLL_WAIT);
        expect_at(24, "pll_tx_rel",   V_TX_REL);
        expect_at(25, "pll_rx_lock",  V_RX_LOCK);
        expect_at(40, "pll_rx_last",  V_RX_LOCK);
        expect_at(41, "pll_ready",    V_READY);
        step(5);
        bus.pll_locked = 1'b1;
        step(40);

        // CDR lock lost for 5 cycles
        bus.rx_freqlocked = 1'b0;
        t0 = cyc;
        expect_at(3,  "rx_sync_dly",  V_READY);
        expect_at(4,  "rx_lost",      V_RX_LOCK);
        expect_at(23, "rx_rl_last",   V_RX_LOCK);
        expect_at(24, "rx_ready",     V_READY);
        step(5);
        bus.rx_freqlocked = 1'b1;
        step(23);

        // single-cycle powerdown request
        bus.powerdown_req = 1'b1;
        t0 = cyc;
        expect_at(1,  "pd_enter",     V_PWRDN);
        expect_at(8,  "pd_min_last",  V_PWRDN);
        expect_at(9,  "pd_pll_wait",  V_PLL_WAIT);
        expect_at(24, "pd_pll_last",  V_PLL_WAIT);
        expect_at(25, "pd_tx_rel",    V_TX_REL);
        expect_at(26, "pd_rx_lock",   V_RX_LOCK);
        expect_at(41, "pd_rx_last",   V_RX_LOCK);
        expect_at(42, "pd_ready",     V_READY);
        step(1);
        bus.powerdown_req = 1'b0;
        step(44);

        // one busy cycle while READY
        bus.rx_oc_busy = 1'b1;
        t0 = cyc;
        expect_at(1,  "rdy_busy",     V_TX_REL);
        expect_at(2,  "rdy_bsy_rx",   V_RX_LOCK);
        expect_at(17, "rdy_bsy_last", V_RX_LOCK);
        expect_at(18, "rdy_bsy_done", V_READY);
        step(1);
        bus.rx_oc_busy = 1'b0;
        step(19);

        // offset cancellation busy for 20 cycles during RX_LOCK
        bus.rx_freqlocked = 1'b0;
        t0 = cyc;
        expect_at(4,  "oc_rx_lock",   V_RX_LOCK);
        expect_at(6,  "oc_pre",       V_RX_LOCK);
        expect_at(7,  "oc_busy",      V_TX_REL);
        expect_at(26, "oc_busy_last", V_TX_REL);
        expect_at(27, "oc_restart",   V_RX_LOCK);
        expect_at(42, "oc_rx_last",   V_RX_LOCK);
        expect_at(43, "oc_ready",     V_READY);
        step(1);
        bus.rx_freqlocked = 1'b1;
        step(5);
        bus.rx_oc_busy = 1'b1;
        step(20);
        bus.rx_oc_busy = 1'b0;
        step(20);

        // CDR lock toggling every 10 cycles never settles
        bus.rx_freqlocked = 1'b0;
        t0 = cyc;
        expect_at(3,  "tg_sync_dly",  V_READY);
        expect_at(4,  "tg_rx_lock",   V_RX_LOCK);
        expect_at(10, "tg_10",        V_RX_LOCK);
        expect_at(25, "tg_25",        V_RX_LOCK);
        expect_at(35, "tg_35",        V_RX_LOCK);
        expect_at(50, "tg_50",        V_RX_LOCK);
        expect_at(60, "tg_60",        V_RX_LOCK);
        for (int i = 0; i < 6; i++) begin
            step(10);
            bus.rx_freqlocked = ~bus.rx_freqlocked;
        end

        // asynchronous reset between clock edges
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", outs(), V_PWRDN);
        step(2);
        chk("reset_hold", outs(), V_PWRDN);
        reset = 1'b0;

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d pending expected 0",
                   sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
